// File: rtl/prescaler_ctrl.sv
// prescaler_ctrl
//   Run-time controller for the system clock prescaler. Produces clk_out from
//   clk with a programmable half-period (half_cur+1 cycles per phase, 50% duty).
//   It starts cleanly from IDLE and stops cleanly, either by truncating a low
//   phase or by finishing a high phase. New half-periods arrive over a
//   valid/ready handshake. While running, a new value is held pending and only
//   takes effect at the next falling edge of clk_out (the "boundary"), so
//   clk_out never produces a runt pulse.
//
// Build option:
//   PRESCALER_CTRL_TICK_EN - when defined, tick is a registered one-cycle pulse
//                            in the first cycle clk_out is high. When undefined,
//                            tick is tied low and its register is not built.
//
// Ports:
//   clk        in   system clock; everything runs on its rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   run request (1 = run, 0 = request a clean stop)
//   cfg_valid  in   new half-period offered
//   cfg_half   in   new half-period minus one
//   cfg_ready  out  controller can accept a configuration (= !pend)
//   clk_out    out  divided clock, period 2*(half_cur+1)
//   tick       out  one-cycle pulse in the first high cycle of clk_out
//   busy       out  controller is not IDLE
//   half_cur   out  half-period currently in effect
module prescaler_ctrl #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] half_cur
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] half_cur_reg;
  logic [CNT_W-1:0] pend_half_reg;
  logic             pend_reg;
  logic             clk_out_reg;

  logic             xfer;
  logic             count_en;
  logic             at_top;
  logic             toggle;
  logic             boundary;

  // Event decode shared by the FSM and the datapath.
  // In RUN with en low and clk_out low, the low phase is truncated: the
  // counter stops and no toggle happens on that edge.
  always_comb begin
    xfer     = cfg_valid && !pend_reg;
    at_top   = (cnt_reg == half_cur_reg);
    count_en = (state_reg == STOP) ||
               ((state_reg == RUN) && (en || clk_out_reg));
    toggle   = count_en && at_top;
    boundary = toggle && clk_out_reg;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        if (!en) begin
          if (!clk_out_reg) begin
            state_next = IDLE;
          end else if (boundary) begin
            // High phase finishes on this very edge: nothing left to wait for.
            state_next = IDLE;
          end else begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (boundary) state_next = en ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_reg != IDLE);
    cfg_ready = !pend_reg;
    clk_out   = clk_out_reg;
    half_cur  = half_cur_reg;
  end

  // Counter and divided clock. Outside a counting edge both are already 0
  // (IDLE holds them there, and the truncation path requires clk_out low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      clk_out_reg <= 1'b0;
    end else begin
      if (!count_en || at_top) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (toggle) clk_out_reg <= ~clk_out_reg;
    end
  end

  // Configuration path. In IDLE a value is applied at once; a value left
  // pending from a truncated stop is applied on the first IDLE edge (cfg_ready
  // is low then, so it cannot collide with a new transfer). While counting,
  // a transfer only fills the pending slot, and the slot is drained at a
  // boundary. A transfer on a boundary edge therefore waits for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cur_reg  <= CNT_W'(DEFAULT_HALF);
      pend_half_reg <= '0;
      pend_reg      <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (pend_reg) begin
        half_cur_reg <= pend_half_reg;
        pend_reg     <= 1'b0;
      end else if (xfer) begin
        half_cur_reg <= cfg_half;
      end
    end else begin
      if (boundary && pend_reg) begin
        half_cur_reg <= pend_half_reg;
        pend_reg     <= 1'b0;
      end
      if (xfer) begin
        pend_half_reg <= cfg_half;
        pend_reg      <= 1'b1;
      end
    end
  end

`ifdef PRESCALER_CTRL_TICK_EN
  logic tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= toggle && !clk_out_reg;
    end
  end

  assign tick = tick_reg;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Bench for prescaler_ctrl. The reference model works at phase level: it
// keeps the clk_out level and the number of edges left until the next toggle,
// reloading that budget with half+1 at each phase start.
module tb_prescaler_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] half_cur;

  prescaler_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .half_cur  (half_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_half;
  int m_left;
  int m_pend_half;
  bit m_active;
  bit m_stopping;
  bit m_level;
  bit m_tick;
  bit m_pend;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_half      = 1;
    m_left      = 0;
    m_pend_half = 0;
    m_active    = 0;
    m_stopping  = 0;
    m_level     = 0;
    m_tick      = 0;
    m_pend      = 0;
  endtask

  // One rising edge of the reference, using the inputs the DUT just sampled.
  task automatic model_step(input bit i_en, input bit i_valid, input int i_half);
    bit xfer;
    xfer   = i_valid && !m_pend;
    m_tick = 0;
    if (xfer) $display("cfg transfer half=%0d active=%0d at %0t", i_half, m_active, $time);
    if (!m_active) begin
      if (m_pend) begin
        m_half = m_pend_half;
        m_pend = 0;
      end else if (xfer) begin
        m_half = i_half;
      end
      if (i_en) begin
        m_active   = 1;
        m_stopping = 0;
        m_left     = m_half + 1;
      end
    end else begin
      if (!m_stopping && !i_en && !m_level) begin
        m_active = 0;   // low phase cut short
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (!m_level) begin
            m_level = 1;
            m_tick  = 1;
          end else begin
            m_level = 0;
            if (m_pend) begin
              m_half = m_pend_half;
              m_pend = 0;
            end
            m_active   = i_en;
            m_stopping = 0;
          end
          m_left = m_half + 1;
        end else if (!i_en && m_level) begin
          m_stopping = 1;
        end
      end
      if (xfer) begin
        m_pend_half = i_half;
        m_pend      = 1;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_tick;
`ifdef PRESCALER_CTRL_TICK_EN
    exp_tick = m_tick;
`else
    exp_tick = 1'b0;
`endif
    check_val("clk_out",   32'(clk_out),   32'(m_level));
    check_val("tick",      32'(tick),      32'(exp_tick));
    check_val("busy",      32'(busy),      32'(m_active));
    check_val("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    check_val("half_cur",  32'(half_cur),  32'(m_half));
  endtask

  // Drive one cycle of inputs, clock it, advance the model, check on negedge.
  task automatic cycle(input bit i_en, input bit i_valid, input int i_half);
    en        = i_en;
    cfg_valid = i_valid;
    cfg_half  = CNT_W'(i_half);
    @(posedge clk);
    model_step(i_en, i_valid, i_half);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int rise_idx;
    int guard;
    bit r_en;

    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    check_val("rst_half_cur", 32'(half_cur), 32'd1);
    rst_n = 1'b1;

    // Default start: clk_out rises on edge 2 (third cycle).
    rise_idx = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, 0);
      if (clk_out && rise_idx < 0) rise_idx = i;
    end
    check_val("start_rise_edge", 32'(rise_idx), 32'd2);

    // Clean stop.
    guard = 0;
    while (m_active && guard < 20) begin
      cycle(0, 0, 0);
      guard++;
    end
    check_val("stop_reached_idle", 32'(busy), 32'd0);

    // IDLE transfer applies at once.
    cycle(0, 1, 3);
    check_val("idle_xfer_half", 32'(half_cur), 32'd3);
    check_val("idle_xfer_ready", 32'(cfg_ready), 32'd1);
    repeat (20) cycle(1, 0, 0);
    while (m_active && guard < 60) begin
      cycle(0, 0, 0);
      guard++;
    end

    // Running at half 1, transfer 4 in the high phase.
    cycle(0, 1, 1);
    guard = 0;
    cycle(1, 0, 0);
    while (!m_level && guard < 20) begin
      cycle(1, 0, 0);
      guard++;
    end
    cycle(1, 1, 4);
    check_val("mid_xfer_ready_low", 32'(cfg_ready), 32'd0);
    repeat (25) cycle(1, 0, 0);

    // Transfer on the exact boundary edge, then a rejected second offer.
    guard = 0;
    while (!(m_active && m_level && m_left == 1) && guard < 40) begin
      cycle(1, 0, 0);
      guard++;
    end
    cycle(1, 1, 2);
    check_val("bnd_keeps_old", 32'(half_cur), 32'd4);
    cycle(1, 1, 7);
    repeat (30) cycle(1, 0, 0);

    // Randomized run.
    r_en = 1;
    for (int i = 0; i < 3000; i++) begin
      int h;
      if ($urandom_range(0, 39) == 0) r_en = !r_en;
      h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5));
      cycle(r_en, $urandom_range(0, 7) == 0, h);
    end

    // Reset while a config is pending and clk_out is high.
    guard = 0;
    while (!(m_pend && m_level && m_left > 1) && guard < 2000) begin
      if (m_active && !m_pend && m_level == 0 && m_left > 1)
        cycle(1, 1, $urandom_range(1, 5));
      else
        cycle(1, 0, 0);
      guard++;
    end
    check_val("rst_setup_pend", 32'(cfg_ready), 32'd0);
    check_val("rst_setup_clk", 32'(clk_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("async_rst_half", 32'(half_cur), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
